// File: rtl/spongent_pkg.sv
`timescale 1ns/1ps
// Shared constants, FSM encoding and round primitives for the SPONGENT-88/80/8 core.
package spongent_pkg;

    localparam int         B         = 88;
    localparam int         R_BITS    = 8;
    localparam int         N_BITS    = 88;
    localparam int         ROUNDS    = 45;
    localparam logic [5:0] LFSR_INIT = 6'h05;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ABSORB,
        S_SQUEEZE,
        S_DONE
    } fsm_t;

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0:    y = 4'hE;
            4'h1:    y = 4'hD;
            4'h2:    y = 4'hB;
            4'h3:    y = 4'h0;
            4'h4:    y = 4'h2;
            4'h5:    y = 4'h1;
            4'h6:    y = 4'h4;
            4'h7:    y = 4'hF;
            4'h8:    y = 4'h7;
            4'h9:    y = 4'hA;
            4'hA:    y = 4'h8;
            4'hB:    y = 4'h5;
            4'hC:    y = 4'h9;
            4'hD:    y = 4'hC;
            4'hE:    y = 4'h3;
            default: y = 4'h6;
        endcase
        return y;
    endfunction

    // Bit j lands on j*(B/4) mod (B-1); the top bit is a fixed point.
    function automatic logic [B-1:0] player(input logic [B-1:0] s);
        logic [B-1:0] p;
        p = '0;
        for (int j = 0; j < B - 1; j++) begin
            p[(j * (B / 4)) % (B - 1)] = s[j];
        end
        p[B-1] = s[B-1];
        return p;
    endfunction

    function automatic logic [5:0] bitrev6(input logic [5:0] x);
        logic [5:0] r;
        for (int k = 0; k < 6; k++) begin
            r[k] = x[5-k];
        end
        return r;
    endfunction

    function automatic logic [5:0] lfsr_step(input logic [5:0] x);
        return {x[4:0], x[5] ^ x[4]};
    endfunction

endpackage

// File: rtl/spongent_round.sv
`timescale 1ns/1ps
// One combinational SPONGENT-88 permutation round: round constants, S-box layer, pLayer.
module spongent_round
    import spongent_pkg::*;
(
    input  logic [B-1:0] state_in,
    input  logic [5:0]   lfsr,
    output logic [B-1:0] state_out
);

    logic [B-1:0] with_rc;
    logic [B-1:0] with_sbox;

    always_comb begin
        with_rc          = state_in;
        with_rc[5:0]     = state_in[5:0] ^ lfsr;
        with_rc[B-1:B-6] = state_in[B-1:B-6] ^ bitrev6(lfsr);
        with_sbox        = '0;
        for (int n = 0; n < B / 4; n++) begin
            with_sbox[4*n +: 4] = sbox4(with_rc[4*n +: 4]);
        end
        state_out = player(with_sbox);
    end

endmodule

// File: rtl/spongent_hash.sv
`timescale 1ns/1ps
// Iterative SPONGENT-88/80/8 hash: parallel message load, one round per clock.
// Build option SPONGENT_HASH_UNROLL2_EN runs two rounds per clock.
module spongent_hash #(
    parameter int MAX_BITS = 264,
    parameter int ROUNDS   = spongent_pkg::ROUNDS
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [MAX_BITS-1:0]             data_in,
    input  logic [31:0]                     databitlen_in,
    input  logic                            en,
    output logic                            rdy,
    output logic [spongent_pkg::N_BITS-1:0] hash_out
);
    import spongent_pkg::*;

    // state     | meaning
    // S_IDLE    | waiting for en, captures message and length
    // S_ABSORB  | xor a block into the rate, then one permutation per block
    // S_SQUEEZE | collect a rate byte, permute, repeat; last byte has no permutation
    // S_DONE    | digest valid while en stays high

    localparam int MSG_W    = MAX_BITS + R_BITS;
    localparam int LEN_W    = $clog2(MAX_BITS + 1);
    localparam int BLK_W    = LEN_W - 3;
    localparam int SQ_BYTES = N_BITS / R_BITS;
`ifdef SPONGENT_HASH_UNROLL2_EN
    localparam int CYC = (ROUNDS + 1) / 2;
`else
    localparam int CYC = ROUNDS;
`endif
    localparam logic [5:0] CNT_START = 6'(CYC - 1);
    localparam logic [3:0] SQ_START  = 4'(SQ_BYTES - 1);

    fsm_t                     fsm_q, fsm_d;
    logic [B-1:0]             st_q;
    logic [B-1:0]             r_in;
    logic [B-1:0]             r1;
    logic [B-1:0]             perm_out;
    logic [5:0]               lfsr_q;
    logic [5:0]               lfsr_adv;
    logic [MSG_W-1:0]         msg_q;
    logic [MSG_W-1:0]         msg_init;
    logic [BLK_W-1:0]         blk_q;
    logic [5:0]               rnd_q;
    logic [3:0]               sq_q;
    logic [N_BITS-R_BITS-1:0] sr_q;
    logic [LEN_W-1:0]         len_c;
    logic [LEN_W:0]           shamt;
    logic [R_BITS-1:0]        blk_in;
    logic                     first_rnd;
    logic                     last_rnd;

    // Left-justify message+pad bit so block k sits at msg_q's top byte after k shifts;
    // bits above the clamped length fall off the top.
    always_comb begin
        len_c    = (databitlen_in > 32'(MAX_BITS)) ? LEN_W'(MAX_BITS) : databitlen_in[LEN_W-1:0];
        shamt    = (LEN_W + 1)'(MSG_W - 1) - {1'b0, len_c};
        msg_init = {{(R_BITS - 1){1'b0}}, data_in, 1'b1} << shamt;
    end

    assign first_rnd = (rnd_q == CNT_START);
    assign last_rnd  = (rnd_q == '0);
    assign blk_in    = (fsm_q == S_ABSORB && first_rnd) ? msg_q[MSG_W-1 -: R_BITS] : '0;
    assign r_in      = {st_q[B-1:R_BITS], st_q[R_BITS-1:0] ^ blk_in};

    spongent_round u_round0 (
        .state_in  (r_in),
        .lfsr      (lfsr_q),
        .state_out (r1)
    );

`ifdef SPONGENT_HASH_UNROLL2_EN
    logic [B-1:0] r2;
    logic [5:0]   lfsr_b;

    assign lfsr_b = lfsr_step(lfsr_q);

    spongent_round u_round1 (
        .state_in  (r1),
        .lfsr      (lfsr_b),
        .state_out (r2)
    );

    // Odd round count: the final cycle of each permutation does a single round.
    assign perm_out = last_rnd ? r1 : r2;
    assign lfsr_adv = last_rnd ? LFSR_INIT : lfsr_step(lfsr_b);
`else
    assign perm_out = r1;
    assign lfsr_adv = last_rnd ? LFSR_INIT : lfsr_step(lfsr_q);
`endif

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            S_IDLE:    if (en) fsm_d = S_ABSORB;
            S_ABSORB:  if (last_rnd && blk_q == '0) fsm_d = S_SQUEEZE;
            S_SQUEEZE: if (sq_q == '0) fsm_d = S_DONE;
            S_DONE:    if (!en) fsm_d = S_IDLE;
            default:   fsm_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) fsm_q <= S_IDLE;
        else      fsm_q <= fsm_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q     <= '0;
            lfsr_q   <= '0;
            msg_q    <= '0;
            blk_q    <= '0;
            rnd_q    <= '0;
            sq_q     <= '0;
            sr_q     <= '0;
            hash_out <= '0;
        end else begin
            case (fsm_q)
                S_IDLE: begin
                    if (en) begin
                        st_q   <= '0;
                        lfsr_q <= LFSR_INIT;
                        msg_q  <= msg_init;
                        blk_q  <= len_c[LEN_W-1:3];
                        rnd_q  <= CNT_START;
                    end
                end
                S_ABSORB: begin
                    st_q   <= perm_out;
                    lfsr_q <= lfsr_adv;
                    if (last_rnd) begin
                        rnd_q <= CNT_START;
                        msg_q <= msg_q << R_BITS;
                        if (blk_q == '0) sq_q <= SQ_START;
                        else             blk_q <= blk_q - 1'b1;
                    end else begin
                        rnd_q <= rnd_q - 6'd1;
                    end
                end
                S_SQUEEZE: begin
                    if (first_rnd) sr_q <= {sr_q[N_BITS-2*R_BITS-1:0], st_q[R_BITS-1:0]};
                    if (sq_q == '0) begin
                        hash_out <= {sr_q, st_q[R_BITS-1:0]};
                    end else begin
                        st_q   <= perm_out;
                        lfsr_q <= lfsr_adv;
                        if (last_rnd) begin
                            rnd_q <= CNT_START;
                            sq_q  <= sq_q - 4'd1;
                        end else begin
                            rnd_q <= rnd_q - 6'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign rdy = (fsm_q == S_DONE);

endmodule

// File: tb/tb_spongent_hash.sv
`timescale 1ns/1ps
// Directed bench for spongent_hash with a bit-level SPONGENT-88 reference model and scoreboard.
module tb_spongent_hash;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [263:0] data_in = '0;
    logic [31:0]  databitlen_in = '0;
    logic         en = 1'b0;
    logic         rdy;
    logic [87:0]  hash_out;

    int total  = 0;
    int passed = 0;

    typedef struct {
        logic [87:0] dig;
        int          lat;
    } exp_t;
    exp_t sb[$];

`ifdef SPONGENT_HASH_UNROLL2_EN
    localparam int CPP = 23;
`else
    localparam int CPP = 45;
`endif
    localparam int BUDGET = 2500;

    localparam logic [3:0] SB [16] = '{4'hE, 4'hD, 4'hB, 4'h0, 4'h2, 4'h1, 4'h4, 4'hF,
                                       4'h7, 4'hA, 4'h8, 4'h5, 4'h9, 4'hC, 4'h3, 4'h6};

    spongent_hash dut (
        .clk           (clk),
        .rst           (rst),
        .data_in       (data_in),
        .databitlen_in (databitlen_in),
        .en            (en),
        .rdy           (rdy),
        .hash_out      (hash_out)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [87:0] obs, input logic [87:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [87:0] model_perm(input logic [87:0] s_in);
        logic [87:0] s;
        logic [87:0] t;
        logic [5:0]  l;
        logic [3:0]  nib;
        s = s_in;
        l = 6'h05;
        for (int r = 0; r < 45; r++) begin
            for (int k = 0; k < 6; k++) begin
                s[k]    = s[k] ^ l[k];
                s[87-k] = s[87-k] ^ l[k];
            end
            for (int n = 0; n < 22; n++) begin
                nib = s[4*n +: 4];
                s[4*n +: 4] = SB[nib];
            end
            t = '0;
            for (int j = 0; j < 87; j++) t[(j * 22) % 87] = s[j];
            t[87] = s[87];
            s = t;
            l = {l[4:0], l[5] ^ l[4]};
        end
        return s;
    endfunction

    function automatic logic [87:0] model_hash(input logic [263:0] d, input int unsigned len_in);
        int          len;
        int          nb;
        int          pos;
        logic [87:0] s;
        logic [87:0] dig;
        logic [7:0]  blk;
        len = (len_in > 264) ? 264 : int'(len_in);
        nb  = len / 8 + 1;
        s   = '0;
        dig = '0;
        for (int k = 0; k < nb; k++) begin
            for (int b = 0; b < 8; b++) begin
                pos = 8 * k + b;
                if (pos < len)       blk[7-b] = d[len-1-pos];
                else if (pos == len) blk[7-b] = 1'b1;
                else                 blk[7-b] = 1'b0;
            end
            s[7:0] = s[7:0] ^ blk;
            s = model_perm(s);
        end
        for (int i = 0; i < 11; i++) begin
            dig = {dig[79:0], s[7:0]};
            if (i < 10) s = model_perm(s);
        end
        return dig;
    endfunction

    function automatic int exp_lat(input int unsigned len_in);
        int len;
        len = (len_in > 264) ? 264 : int'(len_in);
        return CPP * (len / 8 + 1 + 10) + 1;
    endfunction

    // disturb: drop en and scramble the inputs mid-hash, then raise en again before done.
    task automatic run_hash(input logic [263:0] d, input int unsigned len, input string tag,
                            input bit disturb, output logic [87:0] got);
        int   cyc;
        exp_t e;
        exp_t pushed;
        @(negedge clk);
        data_in       = d;
        databitlen_in = len;
        en            = 1'b1;
        pushed.dig = model_hash(d, len);
        pushed.lat = exp_lat(len);
        sb.push_back(pushed);
        @(posedge clk);
        cyc = 0;
        #1;
        while (rdy !== 1'b1 && cyc < BUDGET) begin
            @(posedge clk);
            cyc++;
            #1;
            if (disturb && cyc == 60) begin
                en            = 1'b0;
                data_in       = ~d;
                databitlen_in = 32'd8;
            end
            if (disturb && cyc == 300) en = 1'b1;
        end
        e.dig = '0;
        e.lat = 0;
        if (sb.size() > 0) e = sb.pop_front();
        chk({tag, "_latency"}, 88'(cyc), 88'(e.lat));
        chk({tag, "_digest"}, hash_out, e.dig);
        got = hash_out;
        repeat (5) @(posedge clk);
        #1;
        chk({tag, "_rdy_hold"}, 88'(rdy), 88'(1));
        chk({tag, "_digest_hold"}, hash_out, got);
        en = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_rdy_drop"}, 88'(rdy), 88'(0));
        chk({tag, "_digest_keep"}, hash_out, got);
    endtask

    initial begin
        logic [263:0] hello;
        logic [263:0] pat;
        logic [87:0]  h_hello, h_empty, h7, h8, h264, h1000, h_restart;
        int           abort_at;

        hello = "Hello WorldHello WorldZY";
        pat   = {8'h5B, {8{32'hA5C3_1E96}}};

        rst = 1'b0;
        en  = 1'b0;
        #100;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_rdy", 88'(rdy), 88'(0));
        chk("reset_hash", hash_out, 88'(0));
        repeat (20) @(posedge clk);
        #1;
        chk("idle_rdy", 88'(rdy), 88'(0));
        chk("idle_hash", hash_out, 88'(0));

        run_hash(hello, 192, "hello192", 1'b1, h_hello);
        run_hash(pat, 0, "len0", 1'b0, h_empty);
        run_hash(pat, 7, "len7", 1'b0, h7);
        run_hash(pat, 8, "len8", 1'b0, h8);
        chk("len7_len8_differ", 88'(h7 !== h8), 88'(1));
        run_hash(pat, 1000, "len1000", 1'b0, h1000);
        run_hash(pat, 264, "len264", 1'b0, h264);
        chk("clamp_equal", h1000, h264);

        abort_at = exp_lat(192) - 100;
        @(negedge clk);
        data_in       = hello;
        databitlen_in = 32'd192;
        en            = 1'b1;
        @(posedge clk);
        repeat (abort_at) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b0;
        #1;
        chk("abort_rdy", 88'(rdy), 88'(0));
        chk("abort_hash", hash_out, 88'(0));
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_abort_rdy", 88'(rdy), 88'(0));
        run_hash(hello, 192, "restart", 1'b0, h_restart);
        chk("restart_equal", h_restart, h_hello);
        chk("empty_nonzero", 88'(h_empty !== 88'(0)), 88'(1));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
